bcd_scan_display: RTL and testbench

Time-multiplexed four-digit seven-segment driver that reads the packed BCD outputs of a chain of BCD digit counters and scans them onto a common-anode display. It is the read side of the counter interface: counters drive digit values, and this block samples them once per scan frame so a digit cannot change mid-frame. It sits between the counter chain and the board's AN/SEG pins.

---
 rtl/bcd_scan_display.sv | 141 ++++++++++++++
 tb/tb_bcd_scan_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_scan_display                                              |
// | Purpose  : Four-digit time-multiplexed seven-segment driver for a        |
// |            common-anode display. Packed BCD digits are snapshotted once  |
// |            per scan frame so a digit never changes mid-frame.            |
// | Params   : DIV   - clk cycles per digit slot (DIV >= 2)                  |
// | Ports    : clk    in   system clock, rising edge                         |
// |            clr    in   synchronous active-high reset                     |
// |            enable in   scan enable; low = dark display, scan frozen      |
// |            digits in   [15:0] packed BCD, [3:0] = digit 0 (LSD)          |
// |            seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low        |
// |            an     out  [3:0] anode select, active-low, an[i] = digit i   |
// |            frame  out  one-cycle pulse at frame start (digits sampled)   |
// | Macro    : BLANK_LZ_EN - when defined, leading zeros are blanked         |
// |            (digit 0 is never blanked; codes 10-15 count as non-zero).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bcd_scan_display #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        enable,
    input  logic [15:0] digits,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int               CNT_W       = $clog2(DIV);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [6:0]       c_SEG_DARK  = 7'h7F;
    localparam logic [3:0]       c_AN_DARK   = 4'b1111;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_snap;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_frame;

    logic             w_tick;
    logic             w_frame_start;
    logic [1:0]       w_idx_next;
    logic [15:0]      w_src;
    logic [3:0]       w_value;
    logic             w_blank;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;  // dash for non-BCD codes
        endcase
        return s;
    endfunction

    assign w_tick        = enable && (r_cnt == c_CNT_MAX);
    assign w_idx_next    = r_idx + 2'd1;
    assign w_frame_start = w_tick && (r_idx == 2'd3);

    // On the frame-start edge the snapshot register is only being loaded, so
    // digit 0 is taken straight from the input to keep the frame coherent.
    assign w_src = w_frame_start ? digits : r_snap;

    always_comb begin
        w_value = 4'd0;
        case (w_idx_next)
            2'd0: w_value = w_src[3:0];
            2'd1: w_value = w_src[7:4];
            2'd2: w_value = w_src[11:8];
            2'd3: w_value = w_src[15:12];
            default: w_value = 4'd0;
        endcase
    end

`ifdef BLANK_LZ_EN
    // A slot is blank when it and every more-significant digit are zero.
    always_comb begin
        w_blank = 1'b0;
        case (w_idx_next)
            2'd1: w_blank = (w_src[15:4]  == 12'd0);
            2'd2: w_blank = (w_src[15:8]  == 8'd0);
            2'd3: w_blank = (w_src[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt   <= '0;
            r_idx   <= 2'd3;
            r_snap  <= 16'h0000;
            r_an    <= c_AN_DARK;
            r_seg   <= c_SEG_DARK;
            r_frame <= 1'b0;
        end else if (!enable) begin
            // Counters and snapshot hold; display goes dark.
            r_an    <= c_AN_DARK;
            r_seg   <= c_SEG_DARK;
            r_frame <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_idx   <= w_idx_next;
            r_frame <= w_frame_start;
            if (w_frame_start) begin
                r_snap <= digits;
            end
            if (w_blank) begin
                r_an  <= c_AN_DARK;
                r_seg <= c_SEG_DARK;
            end else begin
                r_an  <= ~(4'b0001 << w_idx_next);
                r_seg <= f_decode(w_value);
            end
        end else begin
            r_cnt   <= r_cnt + c_CNT_ONE;
            r_frame <= 1'b0;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bcd_scan_display                                           |
// | Purpose  : Self-checking bench for bcd_scan_display. A behavioural model |
// |            counts enabled edges since reset and derives the slot, the    |
// |            frame snapshot and the expected pins arithmetically; a        |
// |            compare process checks every cycle, and directed literal      |
// |            checks pin the expected scan sequence.                        |
// | Macro    : BLANK_LZ_EN - selects blanking expectations                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bcd_scan_display;

    localparam int TB_DIV = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        enable;
    logic [15:0] digits;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int total = 0;
    int bad   = 0;

    bcd_scan_display #(.DIV(TB_DIV)) dut (
        .clk    (clk),
        .clr    (clr),
        .enable (enable),
        .digits (digits),
        .seg    (seg),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: n = enabled edges since reset. Every TB_DIV-th
    // enabled edge is a tick; tick k shows slot (k-1) mod 4, slot 0
    // starting a new frame and capturing the digits.
    // ------------------------------------------------------------------
    logic [6:0]  seg_tbl [16];
    int          m_n;
    logic [15:0] m_snap;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_frame;
    bit          m_valid = 1'b0;

    initial begin
        seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
        seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
        seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;
        for (int i = 10; i < 16; i++) seg_tbl[i] = 7'h3F;
    end

    always @(posedge clk) begin
        int          slot;
        logic [15:0] upper;
        if (clr) begin
            m_valid = 1'b1;
            m_n     = 0;
            m_snap  = 16'h0000;
            e_an    = 4'b1111;
            e_seg   = 7'h7F;
            e_frame = 1'b0;
        end else if (!enable) begin
            e_an    = 4'b1111;
            e_seg   = 7'h7F;
            e_frame = 1'b0;
        end else begin
            m_n     = m_n + 1;
            e_frame = 1'b0;
            if (m_n % TB_DIV == 0) begin
                slot = ((m_n / TB_DIV) - 1) % 4;
                if (slot == 0) begin
                    m_snap  = digits;
                    e_frame = 1'b1;
                end
                upper = m_snap >> (4 * slot);
                e_an  = ~(4'(1) << slot);
                e_seg = seg_tbl[upper[3:0]];
`ifdef BLANK_LZ_EN
                if (slot != 0 && upper == 16'h0000) begin
                    e_an  = 4'b1111;
                    e_seg = 7'h7F;
                end
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("model_an",    {12'h0, an},    {12'h0, e_an});
            chk("model_seg",   {9'h0, seg},    {9'h0, e_seg});
            chk("model_frame", {15'h0, frame}, {15'h0, e_frame});
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clr    = 1'b1;
        enable = 1'b1;
        digits = 16'h1234;
        edges(3);
        chk("reset_an",    {12'h0, an},    16'h000F);
        chk("reset_seg",   {9'h0, seg},    16'h007F);
        chk("reset_frame", {15'h0, frame}, 16'h0000);
        clr = 1'b0;

        // Edge numbering restarts at release.
        edges(3);   // edge 3: still dark
        chk("pre_tick_an", {12'h0, an}, 16'h000F);
        edges(1);   // edge 4
        chk("e4_an",    {12'h0, an},    16'h000E);
        chk("e4_seg",   {9'h0, seg},    16'h0019);
        chk("e4_frame", {15'h0, frame}, 16'h0001);
        edges(1);   // edge 5
        chk("e5_frame", {15'h0, frame}, 16'h0000);
        edges(3);   // edge 8
        chk("e8_an",  {12'h0, an},  16'h000D);
        chk("e8_seg", {9'h0, seg},  16'h0030);
        edges(2);   // edge 10
        digits = 16'h5678;
        edges(2);   // edge 12
        chk("e12_an",  {12'h0, an}, 16'h000B);
        chk("e12_seg", {9'h0, seg}, 16'h0024);
        edges(4);   // edge 16
        chk("e16_an",  {12'h0, an}, 16'h0007);
        chk("e16_seg", {9'h0, seg}, 16'h0079);
        edges(4);   // edge 20
        chk("e20_an",    {12'h0, an},    16'h000E);
        chk("e20_seg",   {9'h0, seg},    16'h0000);
        chk("e20_frame", {15'h0, frame}, 16'h0001);

        // Invalid code in digit 1; next frame starts at edge 36.
        digits = 16'h00A0;
        edges(20);  // edge 40
        chk("inv_an",  {12'h0, an}, 16'h000D);
        chk("inv_seg", {9'h0, seg}, 16'h003F);

        // Drop enable mid-slot for 7 cycles.
        edges(1);   // edge 41
        enable = 1'b0;
        edges(1);   // edge 42
        chk("dis_an", {12'h0, an}, 16'h000F);
        edges(6);   // edge 48
        enable = 1'b1;
        edges(2);   // edge 50: resumed, still dark
        chk("reen_dark", {12'h0, an}, 16'h000F);
        edges(1);   // edge 51: tick lands on digit 2
        chk("reen_an",  {12'h0, an}, 16'h000B);
        chk("reen_seg", {9'h0, seg}, 16'h0040);

        // Mid-frame clear, then leading-zero pattern.
        clr    = 1'b1;
        digits = 16'h0070;
        edges(1);   // edge 52
        chk("clr_an",    {12'h0, an},    16'h000F);
        chk("clr_seg",   {9'h0, seg},    16'h007F);
        clr = 1'b0;
        edges(TB_DIV);
        chk("clr_tick_an",    {12'h0, an},    16'h000E);
        chk("clr_tick_frame", {15'h0, frame}, 16'h0001);
        chk("lz_d0_seg",      {9'h0, seg},    16'h0040);
        edges(TB_DIV);
        chk("lz_d1_an",  {12'h0, an}, 16'h000D);
        chk("lz_d1_seg", {9'h0, seg}, 16'h0078);
        edges(TB_DIV);
`ifdef BLANK_LZ_EN
        chk("lz_d2_an",  {12'h0, an}, 16'h000F);
        chk("lz_d2_seg", {9'h0, seg}, 16'h007F);
`else
        chk("lz_d2_an",  {12'h0, an}, 16'h000B);
        chk("lz_d2_seg", {9'h0, seg}, 16'h0040);
`endif
        edges(TB_DIV);
`ifdef BLANK_LZ_EN
        chk("lz_d3_an",  {12'h0, an}, 16'h000F);
`else
        chk("lz_d3_an",  {12'h0, an}, 16'h0007);
        chk("lz_d3_seg", {9'h0, seg}, 16'h0040);
`endif

        // Randomized phase, checked by the per-cycle compare process.
        for (int c = 0; c < 4000; c++) begin
            clr    = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int d = 0; d < 4; d++) begin
                    if ($urandom_range(0, 1) == 0)
                        digits[4*d +: 4] = 4'd0;
                    else
                        digits[4*d +: 4] = 4'($urandom_range(0, 15));
                end
            end
            edges(1);
        end

        edges(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
